host_timer_master: RTL and testbench
====================================

Name: host_timer_master

Overview:
- Avalon-MM initiator that drives the interval timer's 3-bit-address, 16-bit s1 slave port and services its irq.
- Accepts simple commands from local host logic over a valid/ready handshake: set period and start, stop, snapshot, status.
- Sequences the required register writes and reads, and returns 32-bit results.
- Auto-acknowledges timer interrupts and maintains a tick count, so host logic never touches timer registers directly.

Parameters:
- TICK_W, 16, width of the tick counter (wraps modulo 2^TICK_W).
- CONTINUOUS, 1, value written to control bit 1 on start.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=SET_PERIOD, 1=STOP, 2=SNAPSHOT, 3=STATUS.
- cmd_period  in  32  period for SET_PERIOD.
- rsp_valid  out  1  one-cycle pulse, result on rsp_data.
- rsp_data  out  32  result (held until next rsp_valid).
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  serviced-timeout count.
- av_address  out  3  timer register address.
- av_chipselect  out  1  timer chipselect.
- av_write_n  out  1  active-low write.
- av_writedata  out  16  timer write data.
- av_readdata  in  16  timer read data, registered, fixed 1-cycle latency.
- av_irq  in  1  timer interrupt.

Behaviour:
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_data=0, tick=0, tick_count=0.
  - av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - State=IDLE.
- Slave timing:
  - No waitrequest; every access occupies exactly one cycle.
  - Read data for the address presented in cycle N is sampled in cycle N+1.
  - Register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Bus signalling:
  - Bus outputs are registered.
  - av_chipselect=1 only during access states; av_write_n=0 only in write states.
  - Idle bus: chipselect=0, write_n=1.
- IDLE:
  - cmd_ready = !av_irq (combinational from state and av_irq).
  - If av_irq: go to IRQ_ACK; irq takes priority over a pending command.
  - Else on handshake: latch op and period, cmd_ready drops next cycle.
- SET_PERIOD:
  - WR_PL writes addr 2 = period[15:0].
  - WR_PH writes addr 3 = period[31:16].
  - WR_CTRL writes addr 1 = {1'b0 stop, 1'b1 start, CONTINUOUS, 1'b1 ito}.
  - Then RSP with rsp_data=0. Latency: 4 cycles from accept to rsp_valid.
  - The slave force-reloads on each period write, so the start must follow the period writes.
- STOP: WR_CTRL writes addr 1 = 4'b1000 (stop, interrupts disabled). Then RSP with rsp_data=0.
- SNAPSHOT:
  - WR_SNAP writes addr 4, data 0.
  - RD_L reads addr 4.
  - RD_H reads addr 5 and samples snap_l.
  - RD_CAP samples snap_h.
  - RSP returns {snap_h, snap_l}.
- STATUS:
  - RD_S reads addr 0.
  - RD_CAP samples it.
  - RSP returns {30'b0, readdata[1:0]} (bit1 running, bit0 timeout).
- IRQ_ACK:
  - Writes addr 0 with data 0, clearing the timeout.
  - Next cycle: tick=1, tick_count+1 (wraps), return to IDLE.
  - av_irq is already low on that cycle, so no double count.
- RSP: rsp_valid=1 for one cycle, then IDLE. No backpressure on responses.
- A timeout coincident with the status-clear write is lost, because the slave gives the clear priority. This is accepted, not compensated.
- av_irq arriving mid-command is deferred until IDLE, serviced before the next command.
- Reset mid-operation: immediate return to reset values; no partial response is emitted.

Decomposition:
- Shared package host_timer_pkg holds:
  - register address constants;
  - control bit indices (ITO=0, CONT=1, START=2, STOP=3);
  - cmd_op encodings;
  - the state enum.
- Single flat module; no sub-module is warranted.

Test Plan:
- SET_PERIOD 0x0001_86A0 -> bus writes addr2=0x86A0, addr3=0x0001, addr1=0x7 on consecutive cycles; rsp_valid 4 cycles after accept.
- Timer model counting down from period 9, continuous -> av_irq every 10 cycles. Each irq gets an addr0 write within 2 cycles; tick pulses; tick_count reads 3 after 3 timeouts.
- SNAPSHOT with model counter=0x0002_1234 -> addr4 write, then addr4/addr5 reads back-to-back; rsp_data=0x0002_1234.
- STATUS after STOP -> addr1 write of 0x8; status read returns rsp_data=0x0000_0000, or 0x1 if the timeout was not yet cleared.
- av_irq rising while SNAPSHOT is in RD_L -> snapshot completes unchanged; IRQ_ACK precedes the next accept; cmd_ready=0 while av_irq=1.
- reset asserted during WR_PH -> all outputs return to reset values at once; a new SET_PERIOD after release completes normally; tick_count=0.

Source files
------------

// File: rtl/host_timer_pkg.sv
// Shared definitions for the interval-timer host master: register map,
// control bit positions, command encodings and the sequencer state set.
package host_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_SET_PERIOD = 2'd0,
    OP_STOP       = 2'd1,
    OP_SNAPSHOT   = 2'd2,
    OP_STATUS     = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_WR_SNAP,
    ST_RD_L,
    ST_RD_H,
    ST_RD_S,
    ST_RD_CAP,
    ST_IRQ_ACK,
    ST_RSP
  } state_e;

endpackage

// File: rtl/host_timer_master.sv
// Avalon-MM initiator for the interval timer s1 port. Turns host commands
// into register access sequences, returns 32-bit results and services irq.
module host_timer_master
  import host_timer_pkg::*;
#(
  parameter int unsigned TICK_W     = 16,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              av_irq
);

  state_e      state, state_nxt;
  cmd_op_e     op_q;
  logic [31:0] period_q;
  logic [15:0] snap_l_q;
  logic        accept;

  cmd_op_e     op_sel;
  logic [31:0] period_sel;

  logic        cs_nxt;
  logic        wn_nxt;
  logic [2:0]  addr_nxt;
  logic [15:0] wd_nxt;

  // Irq service wins over a waiting command; reset holds ready low.
  always_comb begin
    cmd_ready = (state == ST_IDLE) && !av_irq && !reset;
    accept    = (state == ST_IDLE) && !av_irq && cmd_valid;
  end

  // Bus outputs are registered from the next state, so the first access
  // of a command needs the op/period straight from the command inputs
  // (the latched copies only become valid one cycle later).
  always_comb begin
    op_sel     = (state == ST_IDLE) ? cmd_op_e'(cmd_op) : op_q;
    period_sel = (state == ST_IDLE) ? cmd_period : period_q;
  end

  // Next-state sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (av_irq) begin
          state_nxt = ST_IRQ_ACK;
        end else if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_SET_PERIOD: state_nxt = ST_WR_PL;
            OP_STOP:       state_nxt = ST_WR_CTRL;
            OP_SNAPSHOT:   state_nxt = ST_WR_SNAP;
            default:       state_nxt = ST_RD_S;
          endcase
        end
      end
      ST_WR_PL:   state_nxt = ST_WR_PH;
      ST_WR_PH:   state_nxt = ST_WR_CTRL;
      ST_WR_CTRL: state_nxt = ST_RSP;
      ST_WR_SNAP: state_nxt = ST_RD_L;
      ST_RD_L:    state_nxt = ST_RD_H;
      ST_RD_H:    state_nxt = ST_RD_CAP;
      ST_RD_S:    state_nxt = ST_RD_CAP;
      ST_RD_CAP:  state_nxt = ST_RSP;
      ST_IRQ_ACK: state_nxt = ST_IDLE;
      ST_RSP:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Bus access for the state about to be entered.
  always_comb begin
    cs_nxt   = 1'b0;
    wn_nxt   = 1'b1;
    addr_nxt = '0;
    wd_nxt   = '0;
    case (state_nxt)
      ST_WR_PL: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = REG_PERIODL;
        wd_nxt   = period_sel[15:0];
      end
      ST_WR_PH: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = REG_PERIODH;
        wd_nxt   = period_sel[31:16];
      end
      ST_WR_CTRL: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = REG_CONTROL;
        if (op_sel == OP_STOP) begin
          wd_nxt[CTRL_STOP] = 1'b1;
        end else begin
          wd_nxt[CTRL_START] = 1'b1;
          wd_nxt[CTRL_CONT]  = CONTINUOUS;
          wd_nxt[CTRL_ITO]   = 1'b1;
        end
      end
      ST_WR_SNAP: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = REG_SNAPL;
      end
      ST_RD_L: begin
        cs_nxt   = 1'b1;
        addr_nxt = REG_SNAPL;
      end
      ST_RD_H: begin
        cs_nxt   = 1'b1;
        addr_nxt = REG_SNAPH;
      end
      ST_RD_S: begin
        cs_nxt   = 1'b1;
        addr_nxt = REG_STATUS;
      end
      ST_IRQ_ACK: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = REG_STATUS;
      end
      default: ;
    endcase
  end

  // State register and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_address    <= '0;
      av_writedata  <= '0;
    end else begin
      state         <= state_nxt;
      av_chipselect <= cs_nxt;
      av_write_n    <= wn_nxt;
      av_address    <= addr_nxt;
      av_writedata  <= wd_nxt;
    end
  end

  // Command latch and low snapshot half capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_SET_PERIOD;
      period_q <= '0;
      snap_l_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op_e'(cmd_op);
        period_q <= cmd_period;
      end
      if (state == ST_RD_H) begin
        snap_l_q <= av_readdata;
      end
    end
  end

  // Response pulse and data, loaded on the way into RSP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state_nxt == ST_RSP);
      if (state == ST_WR_CTRL) begin
        rsp_data <= '0;
      end else if (state == ST_RD_CAP) begin
        if (op_q == OP_SNAPSHOT) begin
          rsp_data <= {av_readdata, snap_l_q};
        end else begin
          rsp_data <= {30'b0, av_readdata[1:0]};
        end
      end
    end
  end

  // Tick pulse and wrapping count, one per acknowledged timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= (state == ST_IRQ_ACK);
      if (state == ST_IRQ_ACK) begin
        tick_count <= tick_count + TICK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_host_timer_master.sv
module tb_host_timer_master;
  import host_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tick;
  logic [15:0] tick_count;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_irq;

  int vectors = 0;
  int miscompares = 0;

  logic [20:0] bus;
  assign bus = {av_chipselect, av_write_n, av_address, av_writedata};

  always #5 clk = ~clk;

  host_timer_master #(.TICK_W(16), .CONTINUOUS(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tick(tick), .tick_count(tick_count),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_irq(av_irq)
  );

  // Interval timer slave model
  logic [31:0] m_per = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_snap = '0;
  logic [3:0]  m_ctrl = '0;
  logic        m_run = 1'b0;
  logic        m_to = 1'b0;
  logic [15:0] m_rd = '0;
  logic        poke_cnt = 1'b0;
  logic [31:0] poke_val = '0;
  logic        poke_irq = 1'b0;

  assign av_readdata = m_rd;
  assign av_irq = m_to & m_ctrl[0];

  always @(posedge clk) begin
    if (av_chipselect && av_write_n) begin
      case (av_address)
        3'd0: m_rd <= {14'b0, m_run, m_to};
        3'd1: m_rd <= {12'b0, m_ctrl};
        3'd2: m_rd <= m_per[15:0];
        3'd3: m_rd <= m_per[31:16];
        3'd4: m_rd <= m_snap[15:0];
        3'd5: m_rd <= m_snap[31:16];
        default: m_rd <= 16'h0;
      endcase
    end
    if (m_run) begin
      if (m_cnt == 0) begin
        m_to <= 1'b1;
        m_cnt <= m_per;
        if (!m_ctrl[1]) m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (av_chipselect && !av_write_n) begin
      case (av_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ctrl <= av_writedata[3:0];
          if (av_writedata[3]) m_run <= 1'b0;
          else if (av_writedata[2]) m_run <= 1'b1;
        end
        3'd2: begin m_per[15:0] <= av_writedata; m_cnt <= {m_per[31:16], av_writedata}; end
        3'd3: begin m_per[31:16] <= av_writedata; m_cnt <= {av_writedata, m_per[15:0]}; end
        3'd4, 3'd5: m_snap <= m_cnt;
        default: ;
      endcase
    end
    if (poke_cnt) m_cnt <= poke_val;
    if (poke_irq) begin m_to <= 1'b1; m_ctrl[0] <= 1'b1; end
  end

  // Called at a negedge; returns at the negedge of the first command cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_period = per;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Scans from the current negedge (count 1) for the response pulse.
  task automatic wait_rsp(output logic [31:0] d, output int lat, output bit ok);
    ok = 1'b0; lat = 0; d = '0;
    for (int i = 1; i <= 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; lat = i; d = rsp_data; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vectors++; if (bus !== {1'b0, 1'b1, 3'd0, 16'h0}) begin miscompares++; $display("FAIL reset_bus: got %h expected %h", bus, {1'b0, 1'b1, 3'd0, 16'h0}); end
    vectors++; if ({cmd_ready, rsp_valid, tick} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {cmd_ready, rsp_valid, tick}); end
    vectors++; if (rsp_data !== 32'h0 || tick_count !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h/%h expected 0/0", rsp_data, tick_count); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_set_period();
    bit ok;
    send_cmd(2'd0, 32'h0001_86A0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL setp_accept: got timeout expected accept"); end
    vectors++; if (bus !== {1'b1, 1'b0, 3'd2, 16'h86A0}) begin miscompares++; $display("FAIL setp_wr_pl: got %h expected %h", bus, {1'b1, 1'b0, 3'd2, 16'h86A0}); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL setp_ready_low: got %b expected 0", cmd_ready); end
    @(negedge clk);
    vectors++; if (bus !== {1'b1, 1'b0, 3'd3, 16'h0001}) begin miscompares++; $display("FAIL setp_wr_ph: got %h expected %h", bus, {1'b1, 1'b0, 3'd3, 16'h0001}); end
    @(negedge clk);
    vectors++; if (bus !== {1'b1, 1'b0, 3'd1, 16'h0007}) begin miscompares++; $display("FAIL setp_wr_ctrl: got %h expected %h", bus, {1'b1, 1'b0, 3'd1, 16'h0007}); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL setp_early_rsp: got %b expected 0", rsp_valid); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin miscompares++; $display("FAIL setp_rsp: got %b/%h expected 1/0", rsp_valid, rsp_data); end
    vectors++; if (bus !== {1'b0, 1'b1, 3'd0, 16'h0}) begin miscompares++; $display("FAIL setp_bus_idle: got %h expected %h", bus, {1'b0, 1'b1, 3'd0, 16'h0}); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL setp_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_ticks();
    bit ok, rok, prev_irq;
    logic [31:0] d;
    int lat, ticks, acks, irq_k, prev_rise;
    send_cmd(2'd0, 32'd9, ok);
    wait_rsp(d, lat, rok);
    vectors++; if (!ok || !rok || lat != 4) begin miscompares++; $display("FAIL tick_setp_lat: got %0d expected 4", lat); end
    ticks = 0; acks = 0; irq_k = -100; prev_rise = -100; prev_irq = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (av_irq && !prev_irq) begin
        if (prev_rise >= 0) begin
          vectors++; if (k - prev_rise != 10) begin miscompares++; $display("FAIL irq_interval: got %0d expected 10", k - prev_rise); end
        end
        prev_rise = k; irq_k = k;
      end
      if (av_chipselect && !av_write_n && av_address == 3'd0) begin
        acks++;
        vectors++; if (k - irq_k > 2 || av_writedata !== 16'h0) begin miscompares++; $display("FAIL irq_ack_delay: got %0d cycles data %h expected <=2 data 0", k - irq_k, av_writedata); end
      end
      if (tick) begin
        ticks++;
        vectors++; if (av_irq !== 1'b0) begin miscompares++; $display("FAIL tick_irq_low: got %b expected 0", av_irq); end
      end
      prev_irq = av_irq;
      if (ticks == 3) break;
    end
    vectors++; if (ticks != 3 || acks != 3) begin miscompares++; $display("FAIL tick_total: got %0d ticks %0d acks expected 3/3", ticks, acks); end
    vectors++; if (tick_count !== 16'd3) begin miscompares++; $display("FAIL tick_count: got %0d expected 3", tick_count); end
    @(negedge clk);
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL tick_pulse: got %b expected 0", tick); end
  endtask

  task automatic test_stop_status();
    bit ok, rok;
    logic [31:0] d;
    int lat;
    send_cmd(2'd1, 32'h0, ok);
    vectors++; if (!ok || bus !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin miscompares++; $display("FAIL stop_wr_ctrl: got %h expected %h", bus, {1'b1, 1'b0, 3'd1, 16'h0008}); end
    wait_rsp(d, lat, rok);
    vectors++; if (!rok || lat != 2 || d !== 32'h0) begin miscompares++; $display("FAIL stop_rsp: got lat %0d data %h expected 2/0", lat, d); end
    send_cmd(2'd3, 32'h0, ok);
    vectors++; if (!ok || bus[20:16] !== {1'b1, 1'b1, 3'd0}) begin miscompares++; $display("FAIL status_rd: got %h expected %h", bus[20:16], {1'b1, 1'b1, 3'd0}); end
    wait_rsp(d, lat, rok);
    vectors++; if (!rok || lat != 3 || (d !== 32'h0 && d !== 32'h1)) begin miscompares++; $display("FAIL status_rsp: got lat %0d data %h expected 3/0-or-1", lat, d); end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    bit ok;
    poke_val = 32'h0002_1234; poke_cnt = 1'b1;
    @(negedge clk);
    poke_cnt = 1'b0;
    send_cmd(2'd2, 32'h0, ok);
    vectors++; if (!ok || bus !== {1'b1, 1'b0, 3'd4, 16'h0}) begin miscompares++; $display("FAIL snap_wr: got %h expected %h", bus, {1'b1, 1'b0, 3'd4, 16'h0}); end
    @(negedge clk);
    vectors++; if (bus[20:16] !== {1'b1, 1'b1, 3'd4}) begin miscompares++; $display("FAIL snap_rd_l: got %h expected %h", bus[20:16], {1'b1, 1'b1, 3'd4}); end
    @(negedge clk);
    vectors++; if (bus[20:16] !== {1'b1, 1'b1, 3'd5}) begin miscompares++; $display("FAIL snap_rd_h: got %h expected %h", bus[20:16], {1'b1, 1'b1, 3'd5}); end
    @(negedge clk);
    vectors++; if (av_chipselect !== 1'b0) begin miscompares++; $display("FAIL snap_cap_idle: got %b expected 0", av_chipselect); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0002_1234) begin miscompares++; $display("FAIL snap_rsp: got %b/%h expected 1/00021234", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_irq_during_snapshot();
    bit ok, rok, ack_seen, acc;
    logic [31:0] d;
    logic [15:0] tc0;
    int lat;
    tc0 = tick_count;
    send_cmd(2'd2, 32'h0, ok);
    poke_irq = 1'b1;
    @(negedge clk);
    poke_irq = 1'b0;
    vectors++; if (av_irq !== 1'b1 || bus[20:16] !== {1'b1, 1'b1, 3'd4}) begin miscompares++; $display("FAIL irqsnap_rd_l: got irq %b bus %h expected 1/%h", av_irq, bus[20:16], {1'b1, 1'b1, 3'd4}); end
    @(negedge clk);
    vectors++; if (bus[20:16] !== {1'b1, 1'b1, 3'd5} || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL irqsnap_rd_h: got %h ready %b expected %h/0", bus[20:16], cmd_ready, {1'b1, 1'b1, 3'd5}); end
    @(negedge clk); @(negedge clk);
    vectors++; if (!ok || rsp_valid !== 1'b1 || rsp_data !== 32'h0002_1234) begin miscompares++; $display("FAIL irqsnap_rsp: got %b/%h expected 1/00021234", rsp_valid, rsp_data); end
    cmd_valid = 1'b1; cmd_op = 2'd3;
    ack_seen = 1'b0; acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (av_irq) begin
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ready_during_irq: got %b expected 0", cmd_ready); end
      end
      if (av_chipselect && !av_write_n && av_address == 3'd0) ack_seen = 1'b1;
      if (cmd_ready) begin acc = 1'b1; break; end
    end
    vectors++; if (!acc || !ack_seen) begin miscompares++; $display("FAIL ack_before_accept: got ack %b accept %b expected 1/1", ack_seen, acc); end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(d, lat, rok);
    vectors++; if (!rok || d !== 32'h0) begin miscompares++; $display("FAIL irqsnap_status: got %h expected 0", d); end
    vectors++; if (tick_count !== tc0 + 16'd1) begin miscompares++; $display("FAIL irqsnap_tick_count: got %0d expected %0d", tick_count, tc0 + 16'd1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit ok, rok;
    logic [31:0] d;
    int lat;
    send_cmd(2'd0, 32'h1234_5678, ok);
    vectors++; if (!ok || bus !== {1'b1, 1'b0, 3'd2, 16'h5678}) begin miscompares++; $display("FAIL rst_wr_pl: got %h expected %h", bus, {1'b1, 1'b0, 3'd2, 16'h5678}); end
    @(negedge clk);
    vectors++; if (bus !== {1'b1, 1'b0, 3'd3, 16'h1234}) begin miscompares++; $display("FAIL rst_wr_ph: got %h expected %h", bus, {1'b1, 1'b0, 3'd3, 16'h1234}); end
    reset = 1'b1;
    #1;
    vectors++; if (bus !== {1'b0, 1'b1, 3'd0, 16'h0}) begin miscompares++; $display("FAIL rst_async_bus: got %h expected %h", bus, {1'b0, 1'b1, 3'd0, 16'h0}); end
    vectors++; if ({cmd_ready, rsp_valid, tick} !== 3'b000 || tick_count !== 16'h0) begin miscompares++; $display("FAIL rst_async_out: got %b/%0d expected 000/0", {cmd_ready, rsp_valid, tick}, tick_count); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_rsp: got %b expected 0", rsp_valid); end
    end
    reset = 1'b0;
    @(negedge clk);
    send_cmd(2'd0, 32'd9, ok);
    vectors++; if (!ok || bus !== {1'b1, 1'b0, 3'd2, 16'h0009}) begin miscompares++; $display("FAIL rst_new_wr_pl: got %h expected %h", bus, {1'b1, 1'b0, 3'd2, 16'h0009}); end
    wait_rsp(d, lat, rok);
    vectors++; if (!rok || lat != 4 || d !== 32'h0) begin miscompares++; $display("FAIL rst_new_rsp: got lat %0d data %h expected 4/0", lat, d); end
    vectors++; if (tick_count !== 16'h0) begin miscompares++; $display("FAIL rst_tick_count: got %0d expected 0", tick_count); end
  endtask

  initial begin
    test_reset();
    test_set_period();
    test_ticks();
    test_stop_status();
    test_snapshot();
    test_irq_during_snapshot();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

endmodule
